// File: rtl/colour_bbox_detect.sv
// rtl/colour_bbox_detect.sv - colour window detector with per-frame bounding box on an Avalon-ST video stream
module colour_bbox_detect #(
    parameter int VIDEO_W    = 1280,
    parameter int VIDEO_H    = 720,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] sink_data,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic        sink_ready,
    output logic [23:0] src_data,
    output logic        src_valid,
    output logic        src_sop,
    output logic        src_eop,
    input  logic        src_ready,
    input  logic [7:0]  thr_r_min,
    input  logic [7:0]  thr_g_max,
    input  logic [7:0]  thr_b_max,
    input  logic        hl_en,
    input  logic [23:0] hl_colour,
    output logic [10:0] bbox_x_min,
    output logic [10:0] bbox_x_max,
    output logic [9:0]  bbox_y_min,
    output logic [9:0]  bbox_y_max,
    output logic [19:0] bbox_count,
    output logic        bbox_valid,
    output logic        frame_done,
    output logic        frame_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PIX_W = 21;
    localparam logic [PIX_W-1:0] FRAME_PIX = PIX_W'(VIDEO_W * VIDEO_H);
    localparam logic [PIX_W-1:0] PIX_MAX   = '1;
    localparam logic [10:0]      X_LAST    = 11'(VIDEO_W - 1);
    localparam logic [19:0]      CNT_MAX   = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_VIDEO, ST_CTRL} state_t;

    state_t             state_q, state_d, beat_state;
    logic [10:0]        x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [19:0]        cnt_q, cnt_d;
    logic [10:0]        xmin_q, xmin_d, xmax_q, xmax_d;
    logic [9:0]         ymin_q, ymin_d, ymax_q, ymax_d;
    logic [10:0]        bbox_x_min_q, bbox_x_min_d, bbox_x_max_q, bbox_x_max_d;
    logic [9:0]         bbox_y_min_q, bbox_y_min_d, bbox_y_max_q, bbox_y_max_d;
    logic [19:0]        bbox_count_q, bbox_count_d;
    logic               bbox_valid_q, bbox_valid_d;
    logic               done_q, done_d, err_q, err_d;
    logic               pix_match;

    // stage register between the classifier and the output FIFO: {eop, sop, data}
    logic               stage_valid_q, stage_valid_d;
    logic [25:0]        stage_data_q, stage_data_d;

    logic [25:0]        mem_q [FIFO_DEPTH];
    logic [25:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W:0]     occ_next;
    logic               sink_ready_q, sink_ready_d;
    logic               src_ready_q;
    logic               push, pop;
    logic [25:0]        head;

    // packet parsing, thresholding, repaint and per-frame statistics for each accepted beat
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        pix_d         = pix_q;
        cnt_d         = cnt_q;
        xmin_d        = xmin_q;
        xmax_d        = xmax_q;
        ymin_d        = ymin_q;
        ymax_d        = ymax_q;
        bbox_x_min_d  = bbox_x_min_q;
        bbox_x_max_d  = bbox_x_max_q;
        bbox_y_min_d  = bbox_y_min_q;
        bbox_y_max_d  = bbox_y_max_q;
        bbox_count_d  = bbox_count_q;
        bbox_valid_d  = bbox_valid_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        stage_valid_d = sink_valid;
        stage_data_d  = {sink_eop, sink_sop, sink_data};
        beat_state    = sink_sop ? ST_HEADER : state_q;
        pix_match     = (sink_data[7:0] >= thr_r_min) && (sink_data[15:8] <= thr_g_max) &&
                        (sink_data[23:16] <= thr_b_max);
        if (sink_valid) begin
            case (beat_state)
                ST_HEADER: begin
                    // a sop inside an open packet means the previous eop went missing
                    if (state_q == ST_VIDEO || state_q == ST_CTRL) begin
                        err_d = 1'b1;
                    end
                    x_d    = '0;
                    y_d    = '0;
                    pix_d  = '0;
                    cnt_d  = '0;
                    xmin_d = '0;
                    xmax_d = '0;
                    ymin_d = '0;
                    ymax_d = '0;
                    if (sink_eop) begin
                        state_d = ST_IDLE;
                    end else if (sink_data[3:0] == 4'd0) begin
                        state_d = ST_VIDEO;
                    end else begin
                        state_d = ST_CTRL;
                    end
                end
                ST_VIDEO: begin
                    if (pix_match) begin
                        if (hl_en) begin
                            stage_data_d[23:0] = hl_colour;
                        end
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 20'd1;
                        if (cnt_q == 20'd0) begin
                            xmin_d = x_q;
                            xmax_d = x_q;
                            ymin_d = y_q;
                            ymax_d = y_q;
                        end else begin
                            if (x_q < xmin_q) xmin_d = x_q;
                            if (x_q > xmax_q) xmax_d = x_q;
                            if (y_q < ymin_q) ymin_d = y_q;
                            if (y_q > ymax_q) ymax_d = y_q;
                        end
                    end
                    pix_d = (pix_q == PIX_MAX) ? pix_q : pix_q + PIX_W'(1);
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + 10'd1;
                    end else begin
                        x_d = x_q + 11'd1;
                    end
                    if (sink_eop) begin
                        state_d = ST_IDLE;
                        if (pix_d == FRAME_PIX) begin
                            bbox_x_min_d = xmin_d;
                            bbox_x_max_d = xmax_d;
                            bbox_y_min_d = ymin_d;
                            bbox_y_max_d = ymax_d;
                            bbox_count_d = cnt_d;
                            bbox_valid_d = (cnt_d != 20'd0);
                            done_d       = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_CTRL: begin
                    if (sink_eop) state_d = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign push = stage_valid_q;
    assign pop  = src_valid;
    assign head = mem_q[rd_ptr_q];

    // output FIFO bookkeeping and registered sink_ready; the stage beat counts as occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = stage_data_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        occ_next     = {1'b0, count_d} + {{CNT_W{1'b0}}, stage_valid_d};
        sink_ready_d = (occ_next <= (CNT_W+1)'(FIFO_DEPTH - 2));
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            pix_q         <= '0;
            cnt_q         <= '0;
            xmin_q        <= '0;
            xmax_q        <= '0;
            ymin_q        <= '0;
            ymax_q        <= '0;
            bbox_x_min_q  <= '0;
            bbox_x_max_q  <= '0;
            bbox_y_min_q  <= '0;
            bbox_y_max_q  <= '0;
            bbox_count_q  <= '0;
            bbox_valid_q  <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            sink_ready_q  <= 1'b0;
            src_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_q         <= pix_d;
            cnt_q         <= cnt_d;
            xmin_q        <= xmin_d;
            xmax_q        <= xmax_d;
            ymin_q        <= ymin_d;
            ymax_q        <= ymax_d;
            bbox_x_min_q  <= bbox_x_min_d;
            bbox_x_max_q  <= bbox_x_max_d;
            bbox_y_min_q  <= bbox_y_min_d;
            bbox_y_max_q  <= bbox_y_max_d;
            bbox_count_q  <= bbox_count_d;
            bbox_valid_q  <= bbox_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            sink_ready_q  <= sink_ready_d;
            src_ready_q   <= src_ready;
        end
    end

    assign sink_ready = sink_ready_q;
    assign src_valid  = (count_q != '0) && src_ready_q;
    assign src_data   = head[23:0];
    assign src_sop    = head[24];
    assign src_eop    = head[25];
    assign bbox_x_min = bbox_x_min_q;
    assign bbox_x_max = bbox_x_max_q;
    assign bbox_y_min = bbox_y_min_q;
    assign bbox_y_max = bbox_y_max_q;
    assign bbox_count = bbox_count_q;
    assign bbox_valid = bbox_valid_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
endmodule

// File: tb/tb_colour_bbox_detect.sv
// tb/tb_colour_bbox_detect.sv - directed bench for colour_bbox_detect on a 4x2 frame
module tb_colour_bbox_detect;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] sink_data;
    logic        sink_valid, sink_sop, sink_eop, sink_ready;
    logic [23:0] src_data;
    logic        src_valid, src_sop, src_eop, src_ready;
    logic [7:0]  thr_r_min, thr_g_max, thr_b_max;
    logic        hl_en;
    logic [23:0] hl_colour;
    logic [10:0] bbox_x_min, bbox_x_max;
    logic [9:0]  bbox_y_min, bbox_y_max;
    logic [19:0] bbox_count;
    logic        bbox_valid, frame_done, frame_err;

    colour_bbox_detect #(.VIDEO_W(W), .VIDEO_H(H), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_ready(sink_ready),
        .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_ready(src_ready),
        .thr_r_min(thr_r_min), .thr_g_max(thr_g_max), .thr_b_max(thr_b_max),
        .hl_en(hl_en), .hl_colour(hl_colour),
        .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
        .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max),
        .bbox_count(bbox_count), .bbox_valid(bbox_valid),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    logic [25:0] tx_q[$];
    logic [25:0] exp_q[$];
    logic [25:0] rx_q[$];
    logic [23:0] fr [W*H];
    bit          hit [W*H];
    int          n_tests = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          max_occ = 0;
    bit          rand_rdy = 1'b0;
    int          d0, e0, a0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [23:0] d, input bit s, input bit e, input logic [23:0] ed);
        tx_q.push_back({e, s, d});
        exp_q.push_back({e, s, ed});
    endtask

    task automatic clear_frame();
        for (int i = 0; i < W*H; i++) begin
            fr[i]  = 24'h0;
            hit[i] = 1'b0;
        end
    endtask

    task automatic put_video(input int n, input bit eop_last);
        put(24'h0, 1'b1, 1'b0, 24'h0);
        for (int i = 0; i < n; i++)
            put(fr[i], 1'b0, eop_last && (i == n-1), (hit[i] && hl_en) ? hl_colour : fr[i]);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((tx_q.size() != 0 || rx_q.size() < exp_q.size()) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        check_eq({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check_eq($sformatf("%s_beat%0d", tag, i), rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_box(input string tag, input int x0, input int x1, input int y0, input int y1,
                             input int cnt, input bit v);
        check_eq({tag, "_xmin"}, bbox_x_min, x0);
        check_eq({tag, "_xmax"}, bbox_x_max, x1);
        check_eq({tag, "_ymin"}, bbox_y_min, y0);
        check_eq({tag, "_ymax"}, bbox_y_max, y1);
        check_eq({tag, "_count"}, bbox_count, cnt);
        check_eq({tag, "_valid"}, bbox_valid, v);
    endtask

    // sink driver: a beat is presented only in the cycle after sink_ready was seen high
    initial begin : driver
        logic rdy;
        logic [25:0] b;
        sink_valid = 1'b0;
        sink_data  = 24'h0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        forever begin
            @(negedge clk);
            rdy = sink_ready;
            @(posedge clk);
            #1;
            if (rdy && reset_n && tx_q.size() != 0) begin
                b = tx_q.pop_front();
                sink_valid = 1'b1;
                {sink_eop, sink_sop, sink_data} = b;
            end else begin
                sink_valid = 1'b0;
                sink_sop   = 1'b0;
                sink_eop   = 1'b0;
            end
        end
    end

    // downstream ready, optionally random at 30% duty
    initial begin : ready_gen
        src_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            src_ready = rand_rdy ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // monitor: collects src beats, pulses and in-flight occupancy
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (acc_cnt - pop_cnt > max_occ) max_occ = acc_cnt - pop_cnt;
                if (sink_valid) acc_cnt++;
                if (src_valid) begin
                    rx_q.push_back({src_eop, src_sop, src_data});
                    pop_cnt++;
                end
                if (frame_done) done_cnt++;
                if (frame_err) err_cnt++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        thr_r_min = 8'h80;
        thr_g_max = 8'h40;
        thr_b_max = 8'h40;
        hl_en     = 1'b0;
        hl_colour = 24'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_ctl", {sink_ready, src_valid, src_sop, src_eop, bbox_valid, frame_done, frame_err}, 0);
        check_eq("rst_data", src_data, 0);
        check_box("rst", 0, 0, 0, 0, 0, 1'b0);
        reset_n = 1'b1;

        // single red pixel at (2,1)
        clear_frame();
        fr[6] = 24'h0000FF; hit[6] = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        put_video(8, 1'b1);
        drain("t1");
        check_eq("t1_done", done_cnt - d0, 1);
        check_eq("t1_err", err_cnt - e0, 0);
        check_box("t1", 2, 2, 1, 1, 1, 1'b1);

        // same frame with repaint
        hl_en = 1'b1; hl_colour = 24'h00FF00;
        d0 = done_cnt;
        put_video(8, 1'b1);
        drain("t2");
        check_eq("t2_done", done_cnt - d0, 1);
        check_box("t2", 2, 2, 1, 1, 1, 1'b1);

        // all-black frame
        clear_frame();
        d0 = done_cnt;
        put_video(8, 1'b1);
        drain("t3");
        check_eq("t3_done", done_cnt - d0, 1);
        check_eq("t3_count", bbox_count, 0);
        check_eq("t3_valid", bbox_valid, 0);

        // inclusive-bound matches at (1,0) and (3,1), near-miss pixels elsewhere
        clear_frame();
        fr[0] = 24'h00007F;
        fr[1] = 24'h1010C0; hit[1] = 1'b1;
        fr[2] = 24'h004180;
        fr[5] = 24'h410080;
        fr[7] = 24'h4040FF; hit[7] = 1'b1;
        d0 = done_cnt;
        put_video(8, 1'b1);
        drain("t4");
        check_eq("t4_done", done_cnt - d0, 1);
        check_box("t4", 1, 3, 0, 1, 2, 1'b1);

        // control packet with matching-looking beats, then a frame with one match at (0,1)
        put(24'h00000F, 1'b1, 1'b0, 24'h00000F);
        put(24'h0000FF, 1'b0, 1'b0, 24'h0000FF);
        put(24'h0000FF, 1'b0, 1'b1, 24'h0000FF);
        clear_frame();
        fr[4] = 24'h0000FF; hit[4] = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        put_video(8, 1'b1);
        drain("t5");
        check_eq("t5_done", done_cnt - d0, 1);
        check_eq("t5_err", err_cnt - e0, 0);
        check_box("t5", 0, 0, 1, 1, 1, 1'b1);

        // eop after 7 pixels: error, results held
        clear_frame();
        d0 = done_cnt; e0 = err_cnt;
        put_video(7, 1'b1);
        drain("t6");
        check_eq("t6_err", err_cnt - e0, 1);
        check_eq("t6_done", done_cnt - d0, 0);
        check_box("t6", 0, 0, 1, 1, 1, 1'b1);

        // missing eop, then a good frame with matches at (3,0) and (2,1)
        clear_frame();
        d0 = done_cnt; e0 = err_cnt;
        put_video(3, 1'b0);
        fr[3] = 24'h0000FF; hit[3] = 1'b1;
        fr[6] = 24'h0000FF; hit[6] = 1'b1;
        put_video(8, 1'b1);
        drain("t7");
        check_eq("t7_err", err_cnt - e0, 1);
        check_eq("t7_done", done_cnt - d0, 1);
        check_box("t7", 2, 3, 0, 1, 2, 1'b1);

        // continuous stream against random downstream ready
        hl_en = 1'b0;
        rand_rdy = 1'b1;
        max_occ = 0;
        d0 = done_cnt;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < W*H; i++) fr[i] = 24'($urandom);
            put_video(8, 1'b1);
        end
        drain("t8");
        rand_rdy = 1'b0;
        check_eq("t8_done", done_cnt - d0, 3);
        check_eq("t8_occ_le_depth", (max_occ <= DEPTH), 1);

        // reset in the middle of an over-long frame
        a0 = acc_cnt;
        put(24'h0, 1'b1, 1'b0, 24'h0);
        for (int i = 0; i < 100; i++) put(24'h0000FF, 1'b0, 1'b0, 24'h0000FF);
        for (int n = 0; n < 2000 && (acc_cnt - a0) < 101; n++) @(negedge clk);
        check_eq("t9_accepted", acc_cnt - a0, 101);
        reset_n = 1'b0;
        tx_q.delete();
        #1;
        check_eq("t9_rst_ctl", {sink_ready, src_valid, src_sop, src_eop, bbox_valid, frame_done, frame_err}, 0);
        check_eq("t9_rst_data", src_data, 0);
        check_box("t9_rst", 0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rx_q.delete();
        exp_q.delete();
        acc_cnt = 0;
        pop_cnt = 0;
        reset_n = 1'b1;
        clear_frame();
        fr[6] = 24'h0000FF; hit[6] = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        put_video(8, 1'b1);
        drain("t9");
        check_eq("t9_done", done_cnt - d0, 1);
        check_eq("t9_err", err_cnt - e0, 0);
        check_box("t9", 2, 2, 1, 1, 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
